// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
// Rate words are clk_in cycles per serial bit; values below MIN_RATE are clamped.
package serial_pkg;

    localparam int RATE_W = 14;
    localparam logic [RATE_W-1:0] MIN_RATE = RATE_W'(2);
    localparam int MAX_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: latches the clamped rate at frame acceptance and
// flags the last clk_in cycle of every serial bit while the frame runs.
module bit_timer
    import serial_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic              load,
    input  logic              run,
    input  logic [RATE_W-1:0] rate,
    output logic              bit_end
);

    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;

    // rate_q never drops below MIN_RATE, so rate_q-1 cannot wrap.
    assign bit_end = run && (cnt_q == (rate_q - RATE_W'(1)));

    always_comb begin
        rate_d = rate_q;
        cnt_d  = cnt_q;
        if (load) begin
            rate_d = (rate < MIN_RATE) ? MIN_RATE : rate;
            cnt_d  = '0;
        end else if (run) begin
            cnt_d = bit_end ? '0 : (cnt_q + RATE_W'(1));
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rate_q <= MIN_RATE;
            cnt_q  <= '0;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Transmit controller: frames one word as start, LSB-first data, optional
// parity and stop bits on a registered, idle-high tx line.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [RATE_W-1:0]    rate,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output tx_state_t            dbg_state
);

    // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
    // tx_ready depends only on state, and tx_valid while busy is ignored.
    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;

    assign accept    = tx_valid && (state_q == IDLE);
    assign tx_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    bit_timer u_bit_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .load    (accept),
        .run     (busy),
        .rate    (rate),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    parity_d   = parity_bit(MAX_DATA_W'(tx_data), PARITY_ODD != 0);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: a default-configured instance and a parity/2-stop
// instance, each checked every cycle against a frame-bit reference model.
module tb_serial_tx_ctrl;
    import serial_pkg::*;

    localparam int PAR_EN_B  = 1;
    localparam int PAR_ODD_B = 0;
    localparam int STOP_B    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] rate_a = '0, rate_b = '0;
    logic [7:0]  data_a = '0, data_b = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, ready_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    tx_state_t   dbg_a, dbg_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one slot per instance.
    logic        tx_m[2];
    logic        done_m[2];
    bit          busy_m[2];
    int          cyc[2];
    int          rq[2];
    int          flen[2];
    logic [11:0] fbits[2];

    logic cap[0:127];
    int   done_at[4];
    int   n_done;

    always #5 clk = ~clk;

    serial_tx_ctrl u_dut_a (
        .clk_in    (clk),
        .reset     (reset),
        .rate      (rate_a),
        .tx_data   (data_a),
        .tx_valid  (valid_a),
        .tx_ready  (ready_a),
        .tx        (tx_a),
        .busy      (busy_a),
        .done      (done_a),
        .dbg_state (dbg_a)
    );

    serial_tx_ctrl #(
        .DATA_BITS  (8),
        .PARITY_EN  (PAR_EN_B),
        .PARITY_ODD (PAR_ODD_B),
        .STOP_BITS  (STOP_B)
    ) u_dut_b (
        .clk_in    (clk),
        .reset     (reset),
        .rate      (rate_b),
        .tx_data   (data_b),
        .tx_valid  (valid_b),
        .tx_ready  (ready_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .done      (done_b),
        .dbg_state (dbg_b)
    );

    function automatic logic tx_of(input int i);
        return (i == 0) ? tx_a : tx_b;
    endfunction
    function automatic logic done_of(input int i);
        return (i == 0) ? done_a : done_b;
    endfunction
    function automatic logic ready_of(input int i);
        return (i == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic valid_of(input int i);
        return (i == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic [7:0] data_of(input int i);
        return (i == 0) ? data_a : data_b;
    endfunction
    function automatic logic [13:0] rate_of(input int i);
        return (i == 0) ? rate_a : rate_b;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is an array of line levels (start, data LSB first, parity, stops);
    // cycle c of the frame shows bit c/rate.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                busy_m[i] = 1'b0;
                tx_m[i]   = 1'b1;
                done_m[i] = 1'b0;
                cyc[i]    = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                done_m[i] = 1'b0;
                if (busy_m[i]) begin
                    cyc[i]++;
                    if (cyc[i] == flen[i] * rq[i]) begin
                        busy_m[i] = 1'b0;
                        tx_m[i]   = 1'b1;
                        done_m[i] = 1'b1;
                    end else begin
                        tx_m[i] = fbits[i][cyc[i] / rq[i]];
                    end
                end else if (valid_of(i)) begin
                    rq[i]          = (rate_of(i) < 14'd2) ? 2 : int'(rate_of(i));
                    fbits[i]       = '1;
                    fbits[i][0]    = 1'b0;
                    fbits[i][8:1]  = data_of(i);
                    flen[i]        = 1 + 8 + ((i == 1) ? PAR_EN_B + STOP_B : 1);
                    if (i == 1 && PAR_EN_B != 0)
                        fbits[i][9] = (^data_of(i)) ^ (PAR_ODD_B != 0);
                    cyc[i]    = 0;
                    busy_m[i] = 1'b1;
                    tx_m[i]   = 1'b0;
                end else begin
                    tx_m[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check_bit("tx_a",    tx_a,            tx_m[0]);
            check_bit("done_a",  done_a,          done_m[0]);
            check_bit("busy_a",  busy_a,          busy_m[0]);
            check_bit("ready_a", ready_a,         !busy_m[0]);
            check_bit("state_a", dbg_a == IDLE,   !busy_m[0]);
            check_bit("tx_b",    tx_b,            tx_m[1]);
            check_bit("done_b",  done_b,          done_m[1]);
            check_bit("busy_b",  busy_b,          busy_m[1]);
            check_bit("ready_b", ready_b,         !busy_m[1]);
            check_bit("state_b", dbg_b == IDLE,   !busy_m[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int i, input logic v, input logic [7:0] d, input logic [13:0] r);
        if (i == 0) begin
            valid_a = v; data_a = d; rate_a = r;
        end else begin
            valid_b = v; data_b = d; rate_b = r;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic drive(input int i, input logic [7:0] d, input logic [13:0] r);
        int n = 0;
        set_in(i, 1'b1, d, r);
        while (!ready_of(i) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: dut %0d never ready", i);
        end
        @(negedge clk);
        set_in(i, 1'b0, d, r);
    endtask

    task automatic capture(input int i, input int n);
        n_done = 0;
        for (int k = 0; k < 4; k++) done_at[k] = 0;
        for (int k = 1; k <= n; k++) begin
            cap[k] = tx_of(i);
            if (done_of(i)) begin
                if (n_done < 4) done_at[n_done] = k;
                n_done++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_m[0] || busy_m[1] || done_m[0] || done_m[1]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: model still busy");
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_bit("rst_tx_a",    tx_a,    1'b1);
        check_bit("rst_busy_a",  busy_a,  1'b0);
        check_bit("rst_done_a",  done_a,  1'b0);
        check_bit("rst_ready_a", ready_a, 1'b1);
        check_bit("rst_tx_b",    tx_b,    1'b1);
        check_bit("rst_ready_b", ready_b, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: 0xA5 at rate 4.
        drive(0, 8'hA5, 14'd4);
        capture(0, 42);
        check_bit("basic_start_c1",  cap[1],  1'b0);
        check_bit("basic_start_c4",  cap[4],  1'b0);
        check_bit("basic_d0_c5",     cap[5],  1'b1);
        check_bit("basic_d1_c9",     cap[9],  1'b0);
        check_bit("basic_d6_c32",    cap[32], 1'b0);
        check_bit("basic_d7_c33",    cap[33], 1'b1);
        check_bit("basic_stop_c40",  cap[40], 1'b1);
        check_int("basic_done_cycle", done_at[0], 41);
        check_int("basic_done_count", n_done, 1);
        wait_idle();

        // Back-to-back: 0x00 then 0xFF at rate 2 with valid held.
        set_in(0, 1'b1, 8'h00, 14'd2);
        @(negedge clk);
        set_in(0, 1'b1, 8'hFF, 14'd2);
        n_done = 0;
        for (int k = 0; k < 4; k++) done_at[k] = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 22) set_in(0, 1'b0, 8'hFF, 14'd2);
            cap[k] = tx_a;
            if (done_a) begin
                if (n_done < 4) done_at[n_done] = k;
                n_done++;
            end
            @(negedge clk);
        end
        check_int("b2b_done1", done_at[0], 21);
        check_int("b2b_done2", done_at[1], 42);
        check_int("b2b_count", n_done, 2);
        check_bit("b2b_d0_first", cap[3],  1'b0);
        check_bit("b2b_gap_high", cap[21], 1'b1);
        check_bit("b2b_start2",   cap[22], 1'b0);
        check_bit("b2b_d0_second", cap[24], 1'b1);
        wait_idle();

        // Parity + two stop bits: 0x07 at rate 3.
        drive(1, 8'h07, 14'd3);
        capture(1, 38);
        check_bit("par_d7_c27",    cap[27], 1'b0);
        check_bit("par_bit_c28",   cap[28], 1'b1);
        check_bit("par_bit_c30",   cap[30], 1'b1);
        check_bit("par_stop_c36",  cap[36], 1'b1);
        check_int("par_done_cycle", done_at[0], 37);
        wait_idle();

        // Rate clamp, then rate latched at acceptance.
        drive(0, 8'h01, 14'd0);
        capture(0, 22);
        check_bit("clamp_start_c2", cap[2], 1'b0);
        check_bit("clamp_d0_c3",    cap[3], 1'b1);
        check_bit("clamp_d1_c5",    cap[5], 1'b0);
        check_int("clamp_done_cycle", done_at[0], 21);
        wait_idle();
        drive(0, 8'h3C, 14'd8);
        rate_a = 14'd3;
        capture(0, 85);
        check_bit("latch_start_c8", cap[8],  1'b0);
        check_bit("latch_d0_c9",    cap[9],  1'b0);
        check_bit("latch_d2_c25",   cap[25], 1'b1);
        check_int("latch_done_cycle", done_at[0], 81);
        wait_idle();

        // Reset during data bit 3 (cycles 17..20 at rate 4; bit is 0).
        drive(0, 8'hF0, 14'd4);
        repeat (17) @(negedge clk);
        check_bit("pre_reset_tx", tx_a, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_bit("async_rst_tx",    tx_a,    1'b1);
        check_bit("async_rst_busy",  busy_a,  1'b0);
        check_bit("async_rst_done",  done_a,  1'b0);
        check_bit("async_rst_ready", ready_a, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        drive(0, 8'h5A, 14'd2);
        wait_idle();

        // tx_valid pulsed while busy must not start a frame.
        drive(0, 8'h55, 14'd3);
        repeat (5) @(negedge clk);
        set_in(0, 1'b1, 8'hFF, 14'd5);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00, 14'd5);
        capture(0, 40);
        check_int("ignore_done_count", n_done, 1);
        check_int("ignore_done_cycle", done_at[0], 25);
        check_bit("ignore_idle_high",  cap[35], 1'b1);
        wait_idle();

        // Randomized frames on both instances with input churn mid-frame.
        for (int it = 0; it < 60; it++) begin
            int i;
            i = int'($urandom_range(0, 1));
            drive(i, 8'($urandom), 14'($urandom_range(0, 9)));
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk);
                set_in(i, 1'b0, 8'($urandom), 14'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                set_in(i, 1'b1, 8'($urandom), 14'($urandom_range(0, 9)));
                @(negedge clk);
                set_in(i, 1'b0, 8'h00, 14'd2);
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (%0d checks, %0d failures)", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
